// File: rtl/device_regs_pkg.sv
// Shared types and helpers for the device_regs_param register bank.
package device_regs_pkg;

    localparam int MAX_REGS      = 64;
    localparam int MAX_DATAWIDTH = 64;

    typedef enum logic [1:0] {
        ACC_RW,
        ACC_RO,
        ACC_W1C
    } acc_mode_e;

    typedef struct packed {
        logic [MAX_DATAWIDTH-1:0] rdata;
        logic                     error;
    } rsp_t;

    // RO wins when both mask bits are set for the same register.
    function automatic acc_mode_e acc_mode(input int i,
                                           input logic [MAX_REGS-1:0] ro_mask,
                                           input logic [MAX_REGS-1:0] w1c_mask);
        acc_mode_e mode;
        mode = ACC_RW;
        if (w1c_mask[i]) mode = ACC_W1C;
        if (ro_mask[i])  mode = ACC_RO;
        return mode;
    endfunction

endpackage

// File: rtl/device_regs_rsp_buf.sv
// One-entry response holding register; owns the request/response handshake.
module device_regs_rsp_buf
    import device_regs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_valid_i,
    input  rsp_t rsp_i,
    input  logic rsp_ready_i,
    output logic req_ready_o,
    output logic accept_o,
    output logic rsp_valid_o,
    output rsp_t rsp_o
);

    logic valid_q, valid_d;
    rsp_t rsp_q, rsp_d;

    assign req_ready_o = !valid_q || rsp_ready_i;
    assign accept_o    = req_valid_i && req_ready_o;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        rsp_d   = rsp_q;
        if (accept_o) begin
            valid_d = 1'b1;
            rsp_d   = rsp_i;
        end else if (rsp_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers update only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rsp_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rsp_q   <= rsp_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_o       = rsp_q;

endmodule

// File: rtl/device_regs_param.sv
// Parametrised CSR bank with RW, RO (hardware status) and W1C (event) registers,
// a valid/ready request channel, a back-pressured response channel and an irq.
module device_regs_param
    import device_regs_pkg::*;
#(
    parameter int                            ADDRWIDTH = 4,
    parameter int                            DATAWIDTH = 8,
    parameter int                            NUM_REGS  = 8,
    parameter logic [NUM_REGS-1:0]           RO_MASK   = '0,
    parameter logic [NUM_REGS-1:0]           W1C_MASK  = '0,
    parameter logic [NUM_REGS*DATAWIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wen,
    input  logic [ADDRWIDTH-1:0]          req_addr,
    input  logic [DATAWIDTH-1:0]          req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATAWIDTH-1:0]          rsp_rdata,
    output logic                          rsp_error,
    input  logic [NUM_REGS*DATAWIDTH-1:0] hw_status,
    input  logic [NUM_REGS*DATAWIDTH-1:0] hw_set,
    output logic [NUM_REGS*DATAWIDTH-1:0] reg_out,
    output logic                          irq
);

    localparam logic [MAX_REGS-1:0] RO_EXT  = MAX_REGS'(RO_MASK);
    localparam logic [MAX_REGS-1:0] W1C_EXT = MAX_REGS'(W1C_MASK);

    if (NUM_REGS > 2**ADDRWIDTH || NUM_REGS > MAX_REGS || DATAWIDTH > MAX_DATAWIDTH) begin : g_param_check
        $fatal(1, "device_regs_param: NUM_REGS must fit the address space and package limits");
    end

    logic                               accept;
    logic [NUM_REGS-1:0][DATAWIDTH-1:0] cur_val;
    logic [NUM_REGS-1:0][DATAWIDTH-1:0] w1c_next;
    logic [DATAWIDTH-1:0]               rd_data;
    logic                               addr_ok;
    logic                               ro_hit;
    rsp_t                               rsp_new;
    rsp_t                               rsp_cur;
    logic                               irq_q, irq_d;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam acc_mode_e MODE = acc_mode(i, RO_EXT, W1C_EXT);

        if (MODE == ACC_RO) begin : g_ro
            assign cur_val[i]  = hw_status[i*DATAWIDTH +: DATAWIDTH];
            assign w1c_next[i] = '0;
        end else if (MODE == ACC_W1C) begin : g_w1c
            logic                 wr_hit;
            logic [DATAWIDTH-1:0] val_q, val_d, clr;

            assign wr_hit = accept && req_wen && (req_addr == ADDRWIDTH'(i));

            // Set is OR-ed in after the clear, so a simultaneous set survives.
            always_comb begin
                clr   = wr_hit ? req_wdata : '0;
                val_d = (val_q & ~clr) | hw_set[i*DATAWIDTH +: DATAWIDTH];
            end

            always_ff @(posedge clk) begin
                if (rst) val_q <= '0;
                else     val_q <= val_d;
            end

            assign cur_val[i]  = val_q;
            assign w1c_next[i] = val_d;
        end else begin : g_rw
            logic                 wr_hit;
            logic [DATAWIDTH-1:0] val_q, val_d;

            assign wr_hit = accept && req_wen && (req_addr == ADDRWIDTH'(i));
            assign val_d  = wr_hit ? req_wdata : val_q;

            always_ff @(posedge clk) begin
                if (rst) val_q <= RESET_VAL[i*DATAWIDTH +: DATAWIDTH];
                else     val_q <= val_d;
            end

            assign cur_val[i]  = val_q;
            assign w1c_next[i] = '0;
        end
    end

    always_comb begin
        rd_data = '0;
        addr_ok = 1'b0;
        ro_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (req_addr == ADDRWIDTH'(i)) begin
                rd_data = cur_val[i];
                addr_ok = 1'b1;
                ro_hit  = RO_EXT[i];
            end
        end
    end

    always_comb begin
        rsp_new       = '0;
        rsp_new.error = !addr_ok || (req_wen && ro_hit);
        if (!req_wen && addr_ok) rsp_new.rdata = MAX_DATAWIDTH'(rd_data);
    end

    device_regs_rsp_buf u_rsp_buf (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .rsp_i       (rsp_new),
        .rsp_ready_i (rsp_ready),
        .req_ready_o (req_ready),
        .accept_o    (accept),
        .rsp_valid_o (rsp_valid),
        .rsp_o       (rsp_cur)
    );

    // irq tracks the W1C contents as they will be after this edge.
    assign irq_d = |w1c_next;

    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign irq       = irq_q;
    assign reg_out   = cur_val;
    assign rsp_rdata = rsp_cur.rdata[DATAWIDTH-1:0];
    assign rsp_error = rsp_cur.error;

    logic unused_bits;
    assign unused_bits = ^{hw_set, hw_status, req_wdata, rsp_cur.rdata};

endmodule

// File: tb/tb_device_regs_param.sv
// Directed self-checking bench for device_regs_param with one RO, one W1C
// (also flagged RO on reg 0 to exercise precedence) and six RW registers.
module tb_device_regs_param;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NR = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_error;
    logic [NR*DW-1:0]  hw_status;
    logic [NR*DW-1:0]  hw_set;
    logic [NR*DW-1:0]  reg_out;
    logic              irq;

    int vectors     = 0;
    int miscompares = 0;

    device_regs_param #(
        .ADDRWIDTH (AW),
        .DATAWIDTH (DW),
        .NUM_REGS  (NR),
        .RO_MASK   (8'h01),
        .W1C_MASK  (8'h05),
        .RESET_VAL (64'h0706050403020100)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .hw_status (hw_status),
        .hw_set    (hw_set),
        .reg_out   (reg_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_wen   = wen;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic check_rsp(input string tag, input logic [DW-1:0] rdata, input logic err);
        check({tag, ".valid"}, rsp_valid, 1'b1);
        check({tag, ".rdata"}, rsp_rdata, rdata);
        check({tag, ".error"}, rsp_error, err);
    endtask

    function automatic logic [DW-1:0] slot(input int i);
        return reg_out[i*DW +: DW];
    endfunction

    logic [DW-1:0] exp_rd [NR];

    initial begin
        exp_rd = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

        // Reset with a set pulse on the W1C register that must be ignored.
        rst       = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        hw_status = 64'h00000000000000A5;
        hw_set    = 64'h0000000000FF0000;
        tick();
        tick();
        rst    = 1'b0;
        hw_set = '0;
        check("rst.rsp_valid", rsp_valid, 1'b0);
        check("rst.rsp_rdata", rsp_rdata, 8'h00);
        check("rst.rsp_error", rsp_error, 1'b0);
        check("rst.irq", irq, 1'b0);
        check("rst.req_ready", req_ready, 1'b1);
        check("rst.reg0", slot(0), 8'hA5);
        check("rst.reg1", slot(1), 8'h01);
        check("rst.reg2", slot(2), 8'h00);
        check("rst.reg7", slot(7), 8'h07);

        // Back-to-back reads of every register, one per cycle.
        for (int i = 0; i < NR; i++) begin
            drive(1'b1, 1'b0, AW'(i), '0);
            tick();
            check_rsp($sformatf("rd_all[%0d]", i), exp_rd[i], 1'b0);
            check($sformatf("rd_all[%0d].req_ready", i), req_ready, 1'b1);
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("rd_all.retire", rsp_valid, 1'b0);

        // RO register: write is an error, reads follow hw_status.
        drive(1'b1, 1'b1, 4'd0, 8'h3C);
        tick();
        check_rsp("ro_wr", 8'h00, 1'b1);
        check("ro_wr.reg0", slot(0), 8'hA5);
        drive(1'b1, 1'b0, 4'd0, '0);
        tick();
        check_rsp("ro_rd", 8'hA5, 1'b0);
        hw_status = 64'h000000000000005A;
        #1;
        check("ro_pass", slot(0), 8'h5A);
        tick();
        check_rsp("ro_rd2", 8'h5A, 1'b0);

        // RW register write then read.
        drive(1'b1, 1'b1, 4'd1, 8'h3C);
        tick();
        check_rsp("rw_wr", 8'h00, 1'b0);
        check("rw_wr.reg1", slot(1), 8'h3C);
        drive(1'b1, 1'b0, 4'd1, '0);
        tick();
        check_rsp("rw_rd", 8'h3C, 1'b0);
        drive(1'b0, 1'b0, '0, '0);
        tick();

        // W1C register: set, partial clear, full clear.
        hw_set = 64'h0000000000810000;
        tick();
        hw_set = '0;
        check("w1c_set.irq", irq, 1'b1);
        check("w1c_set.reg2", slot(2), 8'h81);
        drive(1'b1, 1'b1, 4'd2, 8'h01);
        tick();
        check_rsp("w1c_clr1", 8'h00, 1'b0);
        drive(1'b1, 1'b0, 4'd2, '0);
        tick();
        check_rsp("w1c_rd", 8'h80, 1'b0);
        check("w1c_rd.irq", irq, 1'b1);
        drive(1'b1, 1'b1, 4'd2, 8'h80);
        tick();
        check("w1c_clr2.irq", irq, 1'b0);
        check("w1c_clr2.reg2", slot(2), 8'h00);
        drive(1'b0, 1'b0, '0, '0);

        // Reg 0 has both mask bits; RO wins so hw_set on it raises nothing.
        hw_set = 64'h00000000000000FF;
        tick();
        hw_set = '0;
        check("ro_wins.irq", irq, 1'b0);
        check("ro_wins.reg0", slot(0), 8'h5A);

        // Set and clear of the same bit in one cycle: set wins.
        hw_set = 64'h0000000000020000;
        tick();
        check("setclr.pre", slot(2), 8'h02);
        hw_set = 64'h0000000000010000;
        drive(1'b1, 1'b1, 4'd2, 8'h03);
        tick();
        hw_set = '0;
        drive(1'b0, 1'b0, '0, '0);
        check("setclr.reg2", slot(2), 8'h01);
        check("setclr.irq", irq, 1'b1);
        check_rsp("setclr.rsp", 8'h00, 1'b0);
        tick();

        // Back-pressure: response held for three cycles, hw_set still lands.
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 4'd1, '0);
        tick();
        check_rsp("bp.first", 8'h3C, 1'b0);
        drive(1'b1, 1'b1, 4'd1, 8'h99);
        hw_set = 64'h0000000000100000;
        #1;
        check("bp.req_ready", req_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            hw_set = '0;
            check_rsp($sformatf("bp.hold[%0d]", k), 8'h3C, 1'b0);
            check($sformatf("bp.hold[%0d].req_ready", k), req_ready, 1'b0);
            check($sformatf("bp.hold[%0d].reg1", k), slot(1), 8'h3C);
        end
        check("bp.hw_set.reg2", slot(2), 8'h11);
        rsp_ready = 1'b1;
        #1;
        check("bp.release.req_ready", req_ready, 1'b1);
        tick();
        check_rsp("bp.next", 8'h00, 1'b0);
        check("bp.next.reg1", slot(1), 8'h99);
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("bp.drain", rsp_valid, 1'b0);

        // Out-of-range addresses.
        drive(1'b1, 1'b0, 4'd9, '0);
        tick();
        check_rsp("oob_rd", 8'h00, 1'b1);
        drive(1'b1, 1'b1, 4'd15, 8'h55);
        tick();
        check_rsp("oob_wr", 8'h00, 1'b1);
        check("oob_wr.reg7", slot(7), 8'h07);
        check("oob_wr.reg1", slot(1), 8'h99);
        drive(1'b0, 1'b0, '0, '0);
        tick();

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 4'd3, '0);
        tick();
        check_rsp("mid_rst.pending", 8'h03, 1'b0);
        drive(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst.rsp_valid", rsp_valid, 1'b0);
        check("mid_rst.rsp_rdata", rsp_rdata, 8'h00);
        check("mid_rst.rsp_error", rsp_error, 1'b0);
        check("mid_rst.irq", irq, 1'b0);
        check("mid_rst.reg1", slot(1), 8'h01);
        check("mid_rst.reg2", slot(2), 8'h00);
        check("mid_rst.req_ready", req_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/device_regs_param.md
# device_regs_param

Parametrised control/status register bank with NUM_REGS registers of DATAWIDTH bits. It is the next generation of the team's simple device register file. Compared with that file it adds per-register access modes (read/write, read-only hardware status, write-1-to-clear event), a valid/ready request channel, a back-pressured response channel with an error flag, and an interrupt output. It sits between the host bus adapter and device datapath logic.

## Interface
Parameters:
- ADDRWIDTH, 4: request address width; NUM_REGS <= 2**ADDRWIDTH is required.
- DATAWIDTH, 8: register and data width.
- NUM_REGS, 8: number of implemented registers, addresses 0..NUM_REGS-1.
- RO_MASK, 'h00: NUM_REGS bits; bit i = 1 makes register i read-only.
- W1C_MASK, 'h00: NUM_REGS bits; bit i = 1 makes register i write-1-to-clear.
- RESET_VAL, 0: NUM_REGS*DATAWIDTH bits; reset value of RW registers, with register i at bits [i*DATAWIDTH +: DATAWIDTH].

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDRWIDTH  register index.
- req_wdata  in  DATAWIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and for errors.
- rsp_error  out  1  access error.
- hw_status  in  NUM_REGS*DATAWIDTH  live values for RO registers.
- hw_set  in  NUM_REGS*DATAWIDTH  per-bit set pulses for W1C registers.
- reg_out  out  NUM_REGS*DATAWIDTH  current register contents, driven to device logic.
- irq  out  1  registered OR of all W1C register bits.

## Operation
- The access mode of register i is decided as follows: RO_MASK[i] = 1 makes it RO; otherwise W1C_MASK[i] = 1 makes it W1C; otherwise it is RW. If both mask bits are set, RO wins.
- RW register: an accepted write loads req_wdata. An accepted read returns the stored value.
- RO register: a read returns hw_status[i] as sampled on the accept edge. A write is ignored, leaves no state change and responds with rsp_error = 1. The reg_out slice for an RO register equals hw_status[i], passed through combinationally.
- W1C register: next value = (cur & ~clr) | hw_set[i]. clr = req_wdata on an accepted write to i, otherwise 0. When a bit is both set and cleared in the same cycle, the set wins. A read returns the value before the accept edge.
- Address >= NUM_REGS: a read returns 0 and a write is ignored; both respond with rsp_error = 1.
- Every accepted request, read or write, produces exactly one response. Responses come back in order.
- irq is registered: irq = |(all W1C bits) evaluated after the edge.

## Timing
- req_ready = !rsp_valid || rsp_ready. This is combinational, so one request per cycle can be sustained while the consumer holds rsp_ready = 1.
- Accept at edge N: the register update happens at edge N, and rsp_valid = 1 from edge N onward, meaning the response is visible in cycle N+1.
- Read latency is 1 cycle. rsp_rdata and rsp_error stay stable while rsp_valid && !rsp_ready.
- When rsp_valid = 1 and rsp_ready = 0, req_ready = 0. No request is accepted and no bus-side update happens. hw_set updates continue in this state.
- When rsp_ready = 1 and a new request arrives in the same cycle, the old response retires and the new one is loaded at the same edge.
- Reset, applied at any time including mid-handshake:
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, irq = 0.
  - RW registers take RESET_VAL; W1C registers are 0.
  - Any pending response is dropped. req_ready = 1 in the first cycle after rst is released.
  - hw_set is ignored while rst = 1.

## Structure
- Package device_regs_pkg holds:
  - enum acc_mode_e {ACC_RW, ACC_RO, ACC_W1C};
  - function acc_mode(i, RO_MASK, W1C_MASK);
  - struct rsp_t {rdata, error}.
- Sub-module device_regs_rsp_buf: a one-entry response holding register that generates req_ready, rsp_valid and the rsp_t payload.
- The top level contains a generate loop over NUM_REGS that creates per-register update logic according to mode, a read mux, error decode and the irq flop.
- An elaboration-time assertion enforces NUM_REGS <= 2**ADDRWIDTH.

## Test plan
- Reset, then read all 8 registers with RESET_VAL = 'h0706050403020100 and RO_MASK = W1C_MASK = 0. Required: rdata 0x00..0x07 in order, error = 0, one response per cycle with rsp_ready held at 1.
- RO_MASK = 'h01, hw_status[0] = 0xA5. Write 0x3C to addr 0, then read addr 0. Required: write response error = 1; read returns 0xA5 with error = 0.
- W1C_MASK = 'h04. Pulse hw_set[2] = 0x81. Required: irq = 1 one cycle later. Then write 0x01 to addr 2 and read it: read returns 0x80, irq stays 1. Write 0x80: irq = 0.
- On the same cycle, hw_set[2] = 0x01 and a write of 0x01 to addr 2. Required: bit 0 remains 1.
- Hold rsp_ready = 0 for 3 cycles while issuing a read. Required: rsp_valid held, rdata stable, req_ready = 0 throughout. Release: the next request is accepted on the same edge.
- Read addr 9 with NUM_REGS = 8: required rdata = 0, error = 1. Assert rst while rsp_valid = 1: required rsp_valid = 0 after the edge and registers back at their reset values.
